// File: rtl/hub_pkg.sv
// rtl/hub_pkg.sv - shared constants and state encoding for the hub transfer initiator
package hub_pkg;
    localparam int         HUB_AW  = 14;
    localparam logic [3:0] WB_LONG = 4'b1111;
    localparam int         ROM_BIT = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ARM,
        ST_CAPT,
        ST_DONE
    } xfer_state_e;
endpackage

// File: rtl/hub_xfer_if.sv
// rtl/hub_xfer_if.sv - hub memory port and cog-local RAM port seen by the transfer initiator
interface hub_xfer_if import hub_pkg::*; #(parameter int LOC_AW = 9) ();
    logic              ena_bus;
    logic              slot;
    logic              w;
    logic [3:0]        wb;
    logic [HUB_AW-1:0] a;
    logic [31:0]       d;
    logic [31:0]       q;
    logic [LOC_AW-1:0] loc_a;
    logic              loc_we;
    logic [31:0]       loc_d;
    logic [31:0]       loc_q;

    modport master (
        input  ena_bus, slot, q, loc_q,
        output w, wb, a, d, loc_a, loc_we, loc_d
    );

    modport slave (
        output ena_bus, slot, q, loc_q,
        input  w, wb, a, d, loc_a, loc_we, loc_d
    );
endinterface

// File: rtl/hub_xfer.sv
// rtl/hub_xfer.sv - moves blocks of longs between cog-local RAM and hub memory, one long per hub grant
module hub_xfer import hub_pkg::*; #(
    parameter int LOC_AW = 9,
    parameter int CNT_W  = 10
) (
    input  logic              clk_cog,
    input  logic              nres,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [HUB_AW-1:0] hub_base_i,
    input  logic [LOC_AW-1:0] loc_base_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    hub_xfer_if.master        bus
);
    xfer_state_e       state_q, state_d;
    logic              dir_q, dir_d;
    logic [HUB_AW-1:0] hub_ptr_q, hub_ptr_d;
    logic [LOC_AW-1:0] loc_ptr_q, loc_ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [31:0]       buf_q, buf_d;
    logic              w_q, w_d;
    logic [3:0]        wb_q, wb_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic              abort_q, abort_d;
    logic              busy_q, busy_d;
    logic              grant, abort_any, capt;

    assign grant     = bus.ena_bus && bus.slot;
    assign abort_any = abort_i || abort_q;
    assign capt      = (state_q == ST_CAPT);

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            hub_ptr_q  <= '0;
            loc_ptr_q  <= '0;
            rem_q      <= '0;
            buf_q      <= '0;
            w_q        <= 1'b0;
            wb_q       <= 4'b0000;
            fetch_ph_q <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            hub_ptr_q  <= hub_ptr_d;
            loc_ptr_q  <= loc_ptr_d;
            rem_q      <= rem_d;
            buf_q      <= buf_d;
            w_q        <= w_d;
            wb_q       <= wb_d;
            fetch_ph_q <= fetch_ph_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        hub_ptr_d  = hub_ptr_q;
        loc_ptr_d  = loc_ptr_q;
        rem_d      = rem_q;
        buf_d      = buf_q;
        fetch_ph_d = fetch_ph_q;
        abort_d    = abort_q;
        // abort is remembered so a grant+abort on a load still ends after its capture
        if (state_q != ST_IDLE && abort_i) abort_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dir_d      = dir_i;
                    hub_ptr_d  = hub_base_i;
                    loc_ptr_d  = loc_base_i;
                    rem_d      = count_i;
                    abort_d    = 1'b0;
                    fetch_ph_d = 1'b0;
                    if (count_i == '0)  state_d = ST_DONE;
                    else if (dir_i)     state_d = ST_FETCH;
                    else                state_d = ST_ARM;
                end
            end
            ST_FETCH: begin
                // phase 0 presents loc_a, phase 1 sees the RAM's registered loc_q
                if (abort_any) begin
                    state_d = ST_DONE;
                end else if (fetch_ph_q) begin
                    buf_d      = bus.loc_q;
                    fetch_ph_d = 1'b0;
                    state_d    = ST_ARM;
                end else begin
                    fetch_ph_d = 1'b1;
                end
            end
            ST_ARM: begin
                if (grant) begin
                    hub_ptr_d = hub_ptr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (dir_q) begin
                        loc_ptr_d = loc_ptr_q + 1'b1;
                        state_d   = (rem_q == CNT_W'(1) || abort_any) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_d   = ST_CAPT;
                    end
                end else if (abort_any) begin
                    state_d = ST_DONE;
                end
            end
            ST_CAPT: begin
                loc_ptr_d = loc_ptr_q + 1'b1;
                state_d   = (rem_q == '0 || abort_any) ? ST_DONE : ST_ARM;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        w_d    = (state_d == ST_ARM) && dir_d;
        wb_d   = w_d ? WB_LONG : 4'b0000;
        busy_d = (state_d != ST_IDLE);
    end

    // strobes are armed a cycle early and only released onto the bus during the grant
    assign bus.w      = w_q && grant;
    assign bus.wb     = grant ? wb_q : 4'b0000;
    assign bus.a      = hub_ptr_q;
    assign bus.d      = buf_q;
    assign bus.loc_a  = loc_ptr_q;
    assign bus.loc_we = capt;
    assign bus.loc_d  = capt ? bus.q : 32'h0;
    assign busy_o     = busy_q;
    assign done_o     = (state_q == ST_DONE);
endmodule

// File: tb/tb_hub_xfer.sv
// tb/tb_hub_xfer.sv - randomized scoreboard bench for hub_xfer with hub and local memory models
module tb_hub_xfer;
    import hub_pkg::*;
    localparam int LOC_AW = 9;
    localparam int CNT_W  = 10;
    localparam int HUB_N  = 1 << HUB_AW;
    localparam int LOC_N  = 1 << LOC_AW;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } xfer_t;

    logic clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    logic              nres, start_i, dir_i, abort_i, busy_o, done_o;
    logic [HUB_AW-1:0] hub_base_i;
    logic [LOC_AW-1:0] loc_base_i;
    logic [CNT_W-1:0]  count_i;

    hub_xfer_if #(.LOC_AW(LOC_AW)) bus ();

    hub_xfer #(.LOC_AW(LOC_AW), .CNT_W(CNT_W)) dut (
        .clk_cog(clk_cog), .nres(nres), .start_i(start_i), .dir_i(dir_i),
        .hub_base_i(hub_base_i), .loc_base_i(loc_base_i), .count_i(count_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .bus(bus)
    );

    int    checks = 0;
    int    errors = 0;
    xfer_t exp_loc[$];
    xfer_t exp_hub[$];
    int    exp_done = 0;
    logic [31:0] ref_hub [HUB_N];
    logic [31:0] ref_loc [LOC_N];
    logic [31:0] hub_mem [HUB_N];
    logic [31:0] loc_mem [LOC_N];
    logic  env_init;
    bit    manual = 0;
    bit    man_grant = 0;
    int    gap = 2;

    function automatic logic [31:0] hub_init(input int unsigned i);
        if (i >= 32'h100 && i <= 32'h102) return 32'hA0 + i - 32'h100;
        return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] loc_init(input int unsigned i);
        if (i == 32'h1F0) return 32'h11111111;
        if (i == 32'h1F1) return 32'h22222222;
        return (i * 32'h01000193) ^ 32'hC3000000;
    endfunction

    // hub memory (ROM above the boundary bit ignores writes) and local RAM, both read-registered
    always @(posedge clk_cog) begin
        if (env_init) begin
            for (int i = 0; i < HUB_N; i++) hub_mem[i] <= hub_init(i);
            for (int i = 0; i < LOC_N; i++) loc_mem[i] <= loc_init(i);
        end else begin
            if (bus.ena_bus && bus.slot) begin
                if (bus.w && !bus.a[ROM_BIT])
                    for (int b = 0; b < 4; b++)
                        if (bus.wb[b]) hub_mem[bus.a][8*b +: 8] <= bus.d[8*b +: 8];
                bus.q <= hub_mem[bus.a];
            end
            if (bus.loc_we) loc_mem[bus.loc_a] <= bus.loc_d;
            bus.loc_q <= loc_mem[bus.loc_a];
        end
    end

    bit    prev_grant = 0;
    bit    grant_now;
    xfer_t e;
    always @(negedge clk_cog) begin
        if (nres && !env_init) begin
            grant_now = bus.ena_bus && bus.slot;
            if (bus.w) begin
                checks++;
                if (!grant_now) begin
                    errors++; $display("FAIL w_outside_grant: w=1 with grant=%0d, required grant=1", grant_now);
                end
                checks++;
                if (exp_hub.size() == 0) begin
                    errors++; $display("FAIL unexpected_hub_write: a=%h d=%h, required no write", bus.a, bus.d);
                end else begin
                    e = exp_hub.pop_front();
                    if (bus.a != HUB_AW'(e.addr) || bus.d != e.data || bus.wb != WB_LONG) begin
                        errors++;
                        $display("FAIL hub_write: got a=%h d=%h wb=%b, required a=%h d=%h wb=%b",
                                 bus.a, bus.d, bus.wb, HUB_AW'(e.addr), e.data, WB_LONG);
                    end
                end
            end
            if (bus.loc_we) begin
                checks++;
                if (!prev_grant) begin
                    errors++; $display("FAIL capture_latency: loc_we with previous grant=0, required 1");
                end
                checks++;
                if (exp_loc.size() == 0) begin
                    errors++; $display("FAIL unexpected_loc_write: a=%h d=%h, required no write", bus.loc_a, bus.loc_d);
                end else begin
                    e = exp_loc.pop_front();
                    if (bus.loc_a != LOC_AW'(e.addr) || bus.loc_d != e.data) begin
                        errors++;
                        $display("FAIL loc_write: got a=%h d=%h, required a=%h d=%h",
                                 bus.loc_a, bus.loc_d, LOC_AW'(e.addr), e.data);
                    end
                end
            end
            if (done_o) begin
                checks++;
                if (exp_done == 0) begin
                    errors++; $display("FAIL unexpected_done: done=1, required 0");
                end else begin
                    exp_done--;
                    checks++;
                    if (exp_loc.size() != 0 || exp_hub.size() != 0) begin
                        errors++;
                        $display("FAIL done_early: pending loc=%0d hub=%0d, required 0 and 0",
                                 exp_loc.size(), exp_hub.size());
                    end
                end
            end
            prev_grant = grant_now;
        end else begin
            prev_grant = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // advance one cycle, then present this cycle's hub grant (never back-to-back)
    task automatic tick();
        bit g;
        @(posedge clk_cog); #1;
        if (manual) g = man_grant;
        else        g = (gap >= 2) && ($urandom_range(0, 2) == 0);
        gap = g ? 1 : gap + 1;
        bus.ena_bus = g | 1'($urandom_range(0, 1));
        bus.slot    = g | (!bus.ena_bus & 1'($urandom_range(0, 1)));
        #1;
    endtask

    // reference model: block copy with modular pointers; ROM stores leave hub contents unchanged
    task automatic issue(input bit dr, input int unsigned hb, input int unsigned lb,
                         input int unsigned cnt, input int unsigned n_exp);
        for (int unsigned i = 0; i < n_exp; i++) begin
            int unsigned ha = (hb + i) % HUB_N;
            int unsigned la = (lb + i) % LOC_N;
            if (!dr) begin
                exp_loc.push_back('{la, ref_hub[ha]});
                ref_loc[la] = ref_hub[ha];
            end else begin
                exp_hub.push_back('{ha, ref_loc[la]});
                if (ha < (1 << ROM_BIT)) ref_hub[ha] = ref_loc[la];
            end
        end
        exp_done++;
        start_i    = 1'b1;
        dir_i      = dr;
        hub_base_i = HUB_AW'(hb);
        loc_base_i = LOC_AW'(lb);
        count_i    = CNT_W'(cnt);
        tick();
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int budget = 3000;
        while (exp_done > 0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (exp_done != 0) begin
            errors++;
            $display("FAIL %s_timeout: pending done %0d, required 0", name, exp_done);
            exp_done = 0;
            exp_loc.delete();
            exp_hub.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        bit found;
        nres = 1'b0; env_init = 1'b1;
        start_i = 1'b0; dir_i = 1'b0; abort_i = 1'b0;
        hub_base_i = '0; loc_base_i = '0; count_i = '0;
        bus.ena_bus = 1'b0; bus.slot = 1'b0;
        for (int i = 0; i < HUB_N; i++) ref_hub[i] = hub_init(i);
        for (int i = 0; i < LOC_N; i++) ref_loc[i] = loc_init(i);
        repeat (2) @(posedge clk_cog);
        #1;
        env_init = 1'b0;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_w", 32'(bus.w), 32'd0);
        chk("reset_wb", 32'(bus.wb), 32'd0);
        chk("reset_a", 32'(bus.a), 32'd0);
        chk("reset_d", bus.d, 32'd0);
        chk("reset_loc_a", 32'(bus.loc_a), 32'd0);
        chk("reset_loc_we", 32'(bus.loc_we), 32'd0);
        nres = 1'b1;
        tick();

        issue(0, 'h100, 'h010, 3, 3);
        wait_done("load3");
        for (int i = 0; i < 3; i++) chk("load3_mem", loc_mem['h10 + i], 32'hA0 + 32'(i));

        issue(1, 'h1FFF, 'h1F0, 2, 2);
        wait_done("store_rom");
        chk("store_1fff", hub_mem['h1FFF], 32'h11111111);
        chk("rom_2000_kept", hub_mem['h2000], hub_init('h2000));
        issue(0, 'h1FFF, 'h050, 1, 1);
        wait_done("readback");
        chk("readback_1fff", loc_mem['h50], 32'h11111111);

        issue(0, 'h0, 'h0, 0, 0);
        chk("count0_done", 32'(done_o), 32'd1);
        wait_done("count0");

        manual = 1; man_grant = 0;
        tick();
        man_grant = 1;
        issue(0, 'h200, 'h080, 5, 2);
        man_grant = 0;
        tick();
        tick();
        man_grant = 1;
        tick();
        abort_i = 1'b1;
        man_grant = 0;
        tick();
        abort_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            man_grant = (k % 3 == 0);
            tick();
        end
        man_grant = 0;
        chk("abort_busy_clear", 32'(busy_o), 32'd0);
        wait_done("abort");
        manual = 0;

        issue(0, 'h3FFF, 'h1FF, 2, 2);
        wait_done("hub_wrap");

        for (int j = 0; j < 24; j++) begin
            bit          dr  = 1'($urandom_range(0, 1));
            int unsigned hb  = $urandom_range(0, HUB_N - 1);
            int unsigned lb  = $urandom_range(0, LOC_N - 1);
            int unsigned cnt = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) hb = HUB_N - 1 - $urandom_range(0, 2);
            issue(dr, hb, lb, cnt, cnt);
            wait_done("random");
        end

        issue(1, 'h3000, 'h020, 4, 4);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (bus.w) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_store_w_seen: w never 1, required 1");
        end
        nres = 1'b0;
        #1;
        chk("async_reset_w", 32'(bus.w), 32'd0);
        chk("async_reset_wb", 32'(bus.wb), 32'd0);
        chk("async_reset_busy", 32'(busy_o), 32'd0);
        exp_hub.delete();
        exp_loc.delete();
        exp_done = 0;
        tick();
        tick();
        nres = 1'b1;
        tick();
        chk("post_reset_idle", 32'(busy_o), 32'd0);
        issue(0, 'h0100, 'h030, 3, 3);
        wait_done("post_reset_load");
        chk("post_reset_mem", loc_mem['h32], 32'hA2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub_xfer.md
Name: hub_xfer

Overview:
- Hub-bus initiator that moves blocks of 32-bit longs between a cog-local RAM and hub memory.
- Drives the hub memory port: w, wb, a and d outward; registered q back.
- Used for coginit image loads (hub->local) and block stores (local->hub).
- Issues one long per granted hub slot and accounts for the hub's one-cycle registered read latency.

Parameters:
- LOC_AW, 9, local RAM long-address width.
- CNT_W, 10, transfer-count width; the maximum count is 2^CNT_W-1.

Ports:
- clk_cog  in  1  system clock; all state on the rising edge.
- nres  in  1  asynchronous active-low reset.
- ena_bus  in  1  hub bus enable; the hub memory acts only on cycles where this is high.
- slot  in  1  this initiator owns the hub on the current ena_bus cycle; it is a grant only when ena_bus && slot.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- dir  in  1  0 = hub->local (load), 1 = local->hub (store); latched at start.
- hub_base  in  14  starting hub long address; latched at start.
- loc_base  in  LOC_AW  starting local long address; latched at start.
- count  in  CNT_W  number of longs; latched at start.
- abort  in  1  stop after any in-flight capture completes.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse on completion or abort.
- w  out  1  hub write strobe.
- wb  out  4  hub byte enables.
- a  out  14  hub long address.
- d  out  32  hub write data.
- q  in  32  hub read data, valid after the edge that follows a read grant.
- loc_a  out  LOC_AW  local RAM address.
- loc_we  out  1  local RAM write strobe.
- loc_d  out  32  local RAM write data.
- loc_q  in  32  local RAM read data, one cycle after loc_a.

Behaviour:
- Reset (nres low, asynchronous): state=IDLE; busy, done, w, loc_we=0; wb=4'b0000; a, d, loc_a, loc_d, counters=0. This applies mid-transfer too: the hub port is quiesced immediately and no partial write is completed.
- Grant = ena_bus && slot. Grants are at least 2 clk_cog cycles apart (the hub guarantees this); the block need not handle back-to-back grants.
- a, w, wb and d are registered. They are set one cycle ahead so they are stable during the grant cycle. Outside a grant cycle: w=0, wb=0.
- States:
  - IDLE: start -> latch inputs. If count==0 -> DONE. Otherwise -> FETCH if dir=1, ARM if dir=0.
  - FETCH (store only): drive loc_a = loc pointer; next cycle latch loc_q into the d buffer -> ARM.
  - ARM: a = hub pointer. In store mode: w=1, wb=4'b1111, d = buffer, all presented on the grant cycle. On grant: hub pointer += 1; remaining -= 1.
    - Load mode -> CAPT.
    - Store mode: loc pointer += 1; if remaining==0 -> DONE, else -> FETCH.
  - CAPT (load only): the cycle after the grant, loc_we=1, loc_a = loc pointer, loc_d = q. Then loc pointer += 1; if remaining==0 -> DONE, else -> ARM.
  - DONE: done=1 for one cycle; busy=0 on exit -> IDLE.
- Address arithmetic:
  - The hub pointer wraps modulo 2^14.
  - Stores that land at a[13]=1 (ROM) are still issued; the memory ignores them.
  - The local pointer wraps modulo 2^LOC_AW.
- abort:
  - In ARM or FETCH -> DONE; no further grant is used.
  - In CAPT -> finish the local write, then DONE.
  - Abort and grant on the same cycle: the grant's access completes (and its capture, for a load), then DONE.
- start while not IDLE is ignored. start and abort together in IDLE: start wins; abort is evaluated from the next cycle.
- Throughput: one long per grant. Load latency from grant to local write is exactly 1 cycle.

Decomposition:
- Shared package hub_pkg:
  - state encoding constants (IDLE, FETCH, ARM, CAPT, DONE);
  - HUB_AW=14;
  - WB_LONG=4'b1111;
  - ROM boundary bit index 13.
- No sub-module. The address/count counters are inline registers; a separate hub_slot_ctr is not warranted.

Test Plan:
- Load, count=3, hub_base=0x0100, loc_base=0x010; hub preloaded 0xA0..A2 at 0x0100..0102 -> three grants with w=0, a=0x0100..0x0102. loc_we pulses one cycle after each grant with loc_a=0x010..0x012 and loc_d=0xA0..0xA2. Then one done pulse.
- Store, count=2, loc holds 0x11111111, 0x22222222 at 0x1F0..0x1F1, hub_base=0x1FFF -> writes with wb=4'b1111 at a=0x1FFF then 0x2000. Readback of 0x1FFF = 0x11111111; the 0x2000 (ROM) write has no effect.
- count=0 start -> done one cycle later; no grant is used and w never asserts.
- Abort asserted on the cycle of the 2nd grant of a 5-long load -> the 2nd capture completes, done pulses, and remaining grants are unused (w=0, no loc_we).
- nres deasserted (driven low) while w=1 in a store -> w, wb and busy are 0 immediately (asynchronously); after release the state is IDLE and a new start works.
- Hub wrap: load, hub_base=0x3FFF, count=2 -> a=0x3FFF then 0x0000.
